// File: rtl/sattn_mmio_driver_if.sv
// Descriptor, MMIO and result signals between the sparse-attention MMIO driver and its environment.
// master = driver view, slave = sequencer/accelerator view.
interface sattn_mmio_driver_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  logic                  desc_valid;
  logic                  desc_ready;
  logic [31:0]           desc_m_rows;
  logic [31:0]           desc_head_dim_d;
  logic [31:0]           desc_block_size;
  logic [31:0]           desc_k_blocks;
  logic [31:0]           desc_s_tokens;
  logic [31:0]           desc_scale_fp;
  logic [7:0]            desc_cmd;
  logic                  mmio_wen;
  logic                  mmio_ren;
  logic [ADDR_WIDTH-1:0] mmio_addr;
  logic [DATA_WIDTH-1:0] mmio_wdata;
  logic [DATA_WIDTH-1:0] mmio_rdata;
  logic                  res_valid;
  logic                  res_ready;
  logic [63:0]           res_sum;
  logic                  res_timeout;
  logic [31:0]           res_cycles;

  modport master (
    input  desc_valid, desc_m_rows, desc_head_dim_d, desc_block_size, desc_k_blocks,
           desc_s_tokens, desc_scale_fp, desc_cmd, mmio_rdata, res_ready,
    output desc_ready, mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
           res_valid, res_sum, res_timeout, res_cycles
  );

  modport slave (
    output desc_valid, desc_m_rows, desc_head_dim_d, desc_block_size, desc_k_blocks,
           desc_s_tokens, desc_scale_fp, desc_cmd, mmio_rdata, res_ready,
    input  desc_ready, mmio_wen, mmio_ren, mmio_addr, mmio_wdata,
           res_valid, res_sum, res_timeout, res_cycles
  );
endinterface

// File: rtl/sattn_mmio_driver.sv
// MMIO initiator: programs one sparse-attention command, polls CMD until done, returns the checksum.
// Optional macro SATTN_DRV_PERF_EN adds a CMD-to-done cycle counter on res_cycles.
module sattn_mmio_driver #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 64,
  parameter int POLL_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  sattn_mmio_driver_if.master bus,
  output logic                busy
);
  localparam int TW = $clog2(POLL_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_POLL, S_READ, S_RESP} state_e;

  typedef struct packed {
    logic [31:0] m_rows;
    logic [31:0] head_dim_d;
    logic [31:0] block_size;
    logic [31:0] k_blocks;
    logic [31:0] s_tokens;
    logic [31:0] scale_fp;
    logic [7:0]  cmd;
  } desc_t;

  state_e                state_q, state_d;
  desc_t                 desc_q;
  logic [2:0]            widx_q;
  logic [TW-1:0]         timer_q;
  logic [63:0]           sum_q;
  logic                  tmo_q;
  logic [31:0]           cyc_q;
  logic                  done, tmo_hit, has_csum;
  logic [ADDR_WIDTH-1:0] csum_addr;
  logic [31:0]           wfield;

  assign done    = bus.mmio_rdata[0];
  assign tmo_hit = (timer_q == TW'(POLL_TIMEOUT - 1));

  always_comb begin
    has_csum  = 1'b1;
    csum_addr = '0;
    case (desc_q.cmd)
      8'h14:   csum_addr = ADDR_WIDTH'(16'h0068);
      8'h15:   csum_addr = ADDR_WIDTH'(16'h0080);
      8'h16:   csum_addr = ADDR_WIDTH'(16'h0088);
      default: has_csum  = 1'b0;
    endcase
  end

  always_comb begin
    case (widx_q)
      3'd0:    wfield = desc_q.m_rows;
      3'd1:    wfield = desc_q.head_dim_d;
      3'd2:    wfield = desc_q.block_size;
      3'd3:    wfield = desc_q.k_blocks;
      3'd4:    wfield = desc_q.s_tokens;
      3'd5:    wfield = desc_q.scale_fp;
      default: wfield = {24'd0, desc_q.cmd};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    busy            = 1'b0;
    bus.desc_ready  = 1'b0;
    bus.mmio_wen    = 1'b0;
    bus.mmio_ren    = 1'b0;
    bus.mmio_addr   = '0;
    bus.mmio_wdata  = '0;
    bus.res_valid   = 1'b0;
    bus.res_sum     = '0;
    bus.res_timeout = 1'b0;
    bus.res_cycles  = '0;
    // Reset overrides the state decode so strobes drop in the reset cycle itself.
    if (rst) begin
      state_d        = S_IDLE;
      bus.desc_ready = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bus.desc_ready = 1'b1;
          if (bus.desc_valid) state_d = S_WRITE;
        end
        S_WRITE: begin
          busy           = 1'b1;
          bus.mmio_wen   = 1'b1;
          bus.mmio_addr  = ADDR_WIDTH'(7'h30 + {widx_q, 3'b000});
          bus.mmio_wdata = DATA_WIDTH'(wfield);
          if (desc_q.cmd == 8'h00 && widx_q == 3'd5) state_d = S_RESP;
          else if (widx_q == 3'd6)                   state_d = S_POLL;
        end
        S_POLL: begin
          busy          = 1'b1;
          bus.mmio_ren  = 1'b1;
          bus.mmio_addr = ADDR_WIDTH'(16'h0060);
          if (done)         state_d = has_csum ? S_READ : S_RESP;
          else if (tmo_hit) state_d = S_RESP;
        end
        S_READ: begin
          busy          = 1'b1;
          bus.mmio_ren  = 1'b1;
          bus.mmio_addr = csum_addr;
          state_d       = S_RESP;
        end
        S_RESP: begin
          busy            = 1'b1;
          bus.res_valid   = 1'b1;
          bus.res_sum     = sum_q;
          bus.res_timeout = tmo_q;
          bus.res_cycles  = cyc_q;
          if (bus.res_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q  <= '0;
      widx_q  <= '0;
      timer_q <= '0;
      sum_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.desc_valid) begin
          desc_q  <= '{m_rows:     bus.desc_m_rows,   head_dim_d: bus.desc_head_dim_d,
                       block_size: bus.desc_block_size, k_blocks: bus.desc_k_blocks,
                       s_tokens:   bus.desc_s_tokens, scale_fp:   bus.desc_scale_fp,
                       cmd:        bus.desc_cmd};
          widx_q  <= '0;
          timer_q <= '0;
          sum_q   <= '0;
          tmo_q   <= 1'b0;
        end
        S_WRITE: begin
          widx_q <= widx_q + 3'd1;
          if (widx_q == 3'd6) timer_q <= '0;
        end
        // Done beats timeout when both land in the same poll cycle.
        S_POLL: if (!done) begin
          if (tmo_hit) tmo_q   <= 1'b1;
          else         timer_q <= timer_q + 1'b1;
        end
        S_READ:  sum_q <= 64'(bus.mmio_rdata);
        default: ;
      endcase
    end
  end

`ifdef SATTN_DRV_PERF_EN
  logic [31:0] perf_q, perf_nxt;
  assign perf_nxt = (perf_q == '1) ? perf_q : perf_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
      cyc_q  <= '0;
    end else if (state_q == S_IDLE && bus.desc_valid) begin
      cyc_q <= '0;
    end else if (state_q == S_WRITE && widx_q == 3'd6) begin
      perf_q <= '0;
    end else if (state_q == S_POLL) begin
      perf_q <= perf_nxt;
      if (done || tmo_hit) cyc_q <= perf_nxt;
    end
  end
`else
  assign cyc_q = '0;
`endif

endmodule

// File: tb/tb_sattn_mmio_driver.sv
// Directed bench for sattn_mmio_driver: behavioural accelerator slave plus a vector table
// of descriptors, with hand sequences for RESP back-pressure and mid-poll reset.
module tb_sattn_mmio_driver;
  localparam int PT = 24;
  localparam logic [63:0] S68 = 64'hA11C_E5ED_0000_0068;
  localparam logic [63:0] S80 = 64'h0BAD_CAFE_1234_0080;
  localparam logic [63:0] S88 = 64'h7777_5555_3333_0088;
`ifdef SATTN_DRV_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] m, d, b, k, s, sc;
    int          done_after;
    int          stall;
    int          nw, np, nr;
    logic [15:0] raddr;
    logic [63:0] sum;
    logic        tmo;
    logic [31:0] cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   failures = 0;
  int   pcnt = 0;
  int   done_after = 0;
  logic sl_done;
  vec_t vecs [7];

  sattn_mmio_driver_if #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) bus ();

  sattn_mmio_driver #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .POLL_TIMEOUT(PT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Accelerator model: done pulses on the done_after-th poll, busy bit set otherwise.
  always @(posedge clk) begin
    if (bus.mmio_wen) pcnt <= 0;
    else if (bus.mmio_ren && bus.mmio_addr == 16'h0060) pcnt <= pcnt + 1;
  end

  always_comb begin
    sl_done = (done_after != 0) && (pcnt == done_after - 1);
    bus.mmio_rdata = '0;
    if (bus.mmio_ren) begin
      case (bus.mmio_addr)
        16'h0060: bus.mmio_rdata = sl_done ? 64'h1 : 64'h2;
        16'h0068: bus.mmio_rdata = S68;
        16'h0080: bus.mmio_rdata = S80;
        16'h0088: bus.mmio_rdata = S88;
        default:  bus.mmio_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic [31:0] m, input logic [31:0] d,
                              input logic [31:0] s, input int da, input int stall, input int nw,
                              input int np, input int nr, input logic [15:0] raddr,
                              input logic [63:0] sum, input logic tmo, input logic [31:0] cyc);
    vec_t v;
    v.cmd = cmd; v.m = m; v.d = d; v.s = s;
    v.b = 32'h10 + m; v.k = d + 32'd1; v.sc = 32'h3F80_0000 ^ s;
    v.done_after = da; v.stall = stall;
    v.nw = nw; v.np = np; v.nr = nr; v.raddr = raddr;
    v.sum = sum; v.tmo = tmo; v.cyc = PERF ? cyc : 32'd0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] fld [7];
    logic [15:0] raddr;
    int nw, np, nr, bad, n;
    fld = '{v.m, v.d, v.b, v.k, v.s, v.sc, {24'd0, v.cmd}};
    done_after = v.done_after;
    bus.desc_m_rows = v.m;  bus.desc_head_dim_d = v.d; bus.desc_block_size = v.b;
    bus.desc_k_blocks = v.k; bus.desc_s_tokens = v.s;  bus.desc_scale_fp = v.sc;
    bus.desc_cmd = v.cmd;   bus.desc_valid = 1'b1;
    chk($sformatf("v%0d_desc_ready_idle", id), 64'(bus.desc_ready), 64'd1);
    @(negedge clk);
    bus.desc_valid = 1'b0;
    nw = 0; np = 0; nr = 0; bad = 0; n = 0; raddr = '0;
    while (!bus.res_valid && n < 200) begin
      if (bus.mmio_wen && bus.mmio_ren) bad++;
      if (bus.mmio_wen) begin
        if (nw < 7) begin
          chk($sformatf("v%0d_waddr%0d", id, nw), 64'(bus.mmio_addr), 64'(48 + 8 * nw));
          chk($sformatf("v%0d_wdata%0d", id, nw), bus.mmio_wdata, 64'(fld[nw]));
        end
        nw++;
      end else if (bus.mmio_ren) begin
        if (bus.mmio_addr == 16'h0060) np++;
        else begin nr++; raddr = bus.mmio_addr; end
      end else bad++;
      n++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_res_valid", id), 64'(bus.res_valid), 64'd1);
    chk($sformatf("v%0d_nwrites", id), 64'(nw), 64'(v.nw));
    chk($sformatf("v%0d_npolls", id), 64'(np), 64'(v.np));
    chk($sformatf("v%0d_nreads", id), 64'(nr), 64'(v.nr));
    chk($sformatf("v%0d_raddr", id), 64'(raddr), 64'(v.raddr));
    chk($sformatf("v%0d_gap_or_both", id), 64'(bad), 64'd0);
    chk($sformatf("v%0d_sum", id), bus.res_sum, v.sum);
    chk($sformatf("v%0d_timeout", id), 64'(bus.res_timeout), 64'(v.tmo));
    chk($sformatf("v%0d_cycles", id), 64'(bus.res_cycles), 64'(v.cyc));
    chk($sformatf("v%0d_resp_idle_bus", id),
        64'({bus.mmio_wen, bus.mmio_ren, bus.desc_ready, busy}), 64'b0001);
    for (int i = 0; i < v.stall; i++) begin
      bus.desc_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_stall%0d_valid", id, i), 64'(bus.res_valid), 64'd1);
      chk($sformatf("v%0d_stall%0d_sum", id, i), bus.res_sum, v.sum);
      chk($sformatf("v%0d_stall%0d_desc_ready", id, i), 64'(bus.desc_ready), 64'd0);
    end
    bus.desc_valid = 1'b0;
    bus.res_ready  = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk($sformatf("v%0d_after_accept", id),
        64'({bus.desc_ready, busy, bus.res_valid}), 64'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.desc_valid = 1'b0; bus.res_ready = 1'b0; bus.desc_cmd = '0;
    bus.desc_m_rows = '0; bus.desc_head_dim_d = '0; bus.desc_block_size = '0;
    bus.desc_k_blocks = '0; bus.desc_s_tokens = '0; bus.desc_scale_fp = '0;

    //            cmd    m   d   s  done stall nw np nr raddr     sum  tmo cyc
    vecs[0] = mk(8'h14, 2,  4,  8,  3,   0,   7, 3, 1, 16'h68, S68, 0, 3);
    vecs[1] = mk(8'h00, 5,  6,  7,  0,   0,   6, 0, 0, 16'h00, 0,   0, 0);
    vecs[2] = mk(8'h10, 9,  3,  1,  20,  0,   7, 20, 0, 16'h00, 0,  0, 20);
    vecs[3] = mk(8'h14, 1,  1,  1,  0,   0,   7, PT, 0, 16'h00, 0,  1, PT);
    vecs[4] = mk(8'h15, 33, 64, 12, 2,   5,   7, 2, 1, 16'h80, S80, 0, 2);
    vecs[5] = mk(8'h16, 7,  8,  9,  PT,  0,   7, PT, 1, 16'h88, S88, 0, PT);
    vecs[6] = mk(8'h16, 3,  2,  5,  PT-1, 0,  7, PT-1, 1, 16'h88, S88, 0, PT-1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_outputs%0d", i),
          64'({bus.desc_ready, busy, bus.mmio_wen, bus.mmio_ren, bus.res_valid}), 64'b10000);
      chk($sformatf("reset_addr%0d", i), 64'(bus.mmio_addr), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({bus.desc_ready, busy, bus.res_valid}), 64'b100);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset while polling, then a fresh descriptor must start from widx 0.
    done_after = 0;
    bus.desc_cmd = 8'h10; bus.desc_valid = 1'b1;
    @(negedge clk);
    bus.desc_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.mmio_ren; i++) @(negedge clk);
    @(negedge clk);
    chk("midpoll_reached", 64'({bus.mmio_ren, busy}), 64'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midpoll_reset_idle",
        64'({bus.mmio_ren, bus.mmio_wen, busy, bus.desc_ready, bus.res_valid}), 64'b00010);
    run_vec(vecs[0], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sattn_mmio_driver.md
Name: sattn_mmio_driver

Overview:
- Host-side MMIO initiator for the sparse-attention accelerator's register file.
- Accepts one command descriptor over valid/ready, programs the shape/scale registers, then writes CMD.
- Polls the CMD status word until done, reads the command's checksum register, and returns the result over valid/ready.
- Sits between a control CPU/test sequencer and the accelerator's MMIO port.

Parameters:
- ADDR_WIDTH, 16, MMIO address width.
- DATA_WIDTH, 64, MMIO data width.
- POLL_TIMEOUT, 4096, maximum status-poll cycles before abort (>=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- desc_valid  in  1  descriptor valid.
- desc_ready  out  1  descriptor accept.
- desc_m_rows, desc_head_dim_d, desc_block_size, desc_k_blocks, desc_s_tokens, desc_scale_fp  in  32 each  register payloads.
- desc_cmd  in  8  opcode: 0x00 NOP, 0x10-0x16.
- mmio_wen  out  1  write strobe.
- mmio_ren  out  1  read strobe.
- mmio_addr  out  ADDR_WIDTH  byte offset.
- mmio_wdata  out  DATA_WIDTH  write data.
- mmio_rdata  in  DATA_WIDTH  read data, combinational from the addressed register in the same cycle.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_sum  out  64  checksum.
- res_timeout  out  1  poll timed out.
- res_cycles  out  32  CMD-to-done cycle count (see Optional Feature).
- busy  out  1  high in any state except IDLE.

Behaviour:
- Single clock, synchronous active-high reset. In reset and in IDLE: all outputs 0 except desc_ready=1. Internal latches cleared.
- FSM states: IDLE, WRITE, POLL, READ, RESP.
- IDLE:
  - desc_ready=1.
  - On desc_valid, latch all desc_* fields, set widx=0, go WRITE. Payload is taken in the handshake cycle.
- WRITE: one write per cycle, mmio_wen=1, mmio_wdata = zero-extended field. Order by widx:
  - 0: 0x30 m_rows
  - 1: 0x38 head_dim_d
  - 2: 0x40 block_size
  - 3: 0x48 k_blocks
  - 4: 0x50 s_tokens
  - 5: 0x58 scale_fp
  - 6: 0x60 cmd (wdata[7:0]=cmd)
- WRITE exit:
  - cmd==0x00: after widx 5, go RESP with sum=0, timeout=0. CMD is never written.
  - Otherwise: after widx 6, go POLL with timer cleared.
- POLL:
  - Each cycle drive mmio_ren=1, addr=0x60, and sample mmio_rdata[0] at the clock edge. Bit[1] (busy) is ignored.
  - The done bit is high for exactly one cycle, so the driver polls every cycle with no gaps.
  - On rdata[0]=1: go READ if cmd has a checksum register, else go RESP with sum=0.
  - Checksum registers: 0x14 -> 0x68; 0x15 -> 0x80; 0x16 -> 0x88.
  - Otherwise timer++. When timer reaches POLL_TIMEOUT-1 without done, go RESP with timeout=1, sum=0.
  - Done and timeout in the same cycle: done wins.
- READ: one cycle, mmio_ren=1, addr = checksum register, latch mmio_rdata into sum, go RESP. This cycle is the one after done detection, which is when the accelerator's checksum latch becomes valid.
- RESP:
  - res_valid=1. res_sum, res_timeout and res_cycles are held stable until res_ready.
  - On res_valid&&res_ready, go IDLE. desc_ready rises the next cycle; no descriptor is accepted in the RESP cycle.
- mmio_wen and mmio_ren are never both high. mmio_addr/mmio_wdata are 0 when no strobe is active.
- Reset mid-operation: return to IDLE on the next edge; strobes drop immediately. No cleanup transactions are issued to the accelerator.
- Minimum latency for a checksum command: handshake + 7 write cycles + N poll cycles + 1 read + RESP.

Optional Feature:
- Macro SATTN_DRV_PERF_EN.
- Defined:
  - 32-bit counter clears on the CMD write cycle (widx 6) and increments every POLL cycle.
  - Value at done or timeout is latched into res_cycles, saturating at 0xFFFFFFFF.
- Undefined: res_cycles tied to 0 and the counter is absent.

Test Plan:
- Desc cmd=0x14, m=2, d=4, s=8 against the accelerator -> writes to 0x30,0x38,0x40,0x48,0x50,0x58,0x60 on 7 consecutive cycles; polls 0x60 until done; one read of 0x68; res_sum equals the accelerator's ACC_SUM; res_timeout=0.
- Behavioural slave that never sets done, POLL_TIMEOUT=16 -> exactly 16 POLL cycles, then res_valid=1, res_timeout=1, res_sum=0, no READ cycle.
- desc_cmd=0x00 -> exactly 6 writes, no write to 0x60, no ren; res_valid the cycle after the 0x58 write with res_sum=0.
- cmd=0x10, done after 20 polls -> no READ cycle, res_sum=0; with SATTN_DRV_PERF_EN, res_cycles=20.
- cmd=0x15, res_ready held low 5 cycles in RESP -> res_valid and res_sum stable, desc_ready=0 throughout; accept -> desc_ready=1 the following cycle.
- rst asserted for 1 cycle during POLL -> next cycle mmio_ren=0, busy=0, desc_ready=1; a new descriptor then runs the full sequence from widx 0.
